trace_buffer: RTL and testbench
===============================

TRACE_BUFFER -- requirements
Module: trace_buffer

Interface
REQ-001 Parameter DEPTH, default 16, number of trace entries; SHALL be a power of two and at least 4.
REQ-002 Parameter POST_W, default 8, width of the post-trigger counter.
REQ-003 clk  input  1  rising-edge clock, single clock domain.
REQ-004 reset  input  1  asynchronous reset, active-low (asserted at 0).
REQ-005 cap_valid  input  1  a retired instruction sample is present this cycle.
REQ-006 cap_entry  input  ENTRY_W=167  packed sample {pc[31:0], instr[31:0], reg_we, reg_addr[4:0], reg_wdata[31:0], mem_we, mem_addr[31:0], mem_wdata[31:0]}, MSB first.
REQ-007 trig_en  input  1  enables PC-match trigger.
REQ-008 trig_pc  input  32  trigger PC value.
REQ-009 post_count  input  POST_W  samples to capture after the trigger sample; sampled on trigger.
REQ-010 arm  input  1  start a capture session (pulse).
REQ-011 stop  input  1  force end of capture (pulse).
REQ-012 clear  input  1  discard contents, return to idle (pulse).
REQ-013 rd_ready  input  1  consumer accepts rd_entry.
REQ-014 rd_valid  output  1  rd_entry holds the oldest unread entry.
REQ-015 rd_entry  output  ENTRY_W  oldest stored entry; all zeros when rd_valid=0.
REQ-016 count  output  clog2(DEPTH)+1  entries stored.
REQ-017 state  output  2  IDLE=00, ARMED=01, POST=10, DONE=11.
REQ-018 overflow  output  1  sticky: at least one entry was overwritten this session.

Function
REQ-019 IDLE: samples ignored; arm SHALL zero wr_ptr, rd_ptr, count and overflow and enter ARMED next cycle.
REQ-020 ARMED/POST: each cap_valid SHALL write cap_entry at wr_ptr, with wr_ptr wrapping modulo DEPTH.
REQ-021 A write when count=DEPTH SHALL overwrite the oldest entry, advance rd_ptr, hold count at DEPTH and set overflow.
REQ-022 In ARMED, cap_valid with trig_en=1 and cap_entry.pc==trig_pc SHALL store the trigger sample and load remaining=post_count.
REQ-023 After a trigger, the block SHALL enter DONE if post_count=0, otherwise POST.
REQ-024 In POST, each write SHALL decrement remaining; the write that makes remaining 0 SHALL move the block to DONE next cycle.
REQ-025 With trig_en=0, ARMED SHALL capture indefinitely until stop or clear.
REQ-026 stop in ARMED/POST SHALL enter DONE, and a same-cycle sample SHALL still be written; stop in IDLE/DONE SHALL be ignored.
REQ-027 DONE: samples ignored; rd_valid=(count>0); rd_entry SHALL be combinational from storage at rd_ptr.
REQ-028 rd_valid&&rd_ready SHALL advance rd_ptr (wrap) and decrement count; at count=0 the block stays in DONE.
REQ-029 arm in DONE SHALL discard contents and re-enter ARMED as in REQ-019; arm in ARMED/POST SHALL be ignored.
REQ-030 clear in any state SHALL enter IDLE with pointers, count and overflow zeroed; priority is clear > stop > arm > capture/read.
REQ-031 rd_valid SHALL be 0 in IDLE, ARMED and POST.

Reset
REQ-032 reset=0 SHALL immediately, without a clock edge, force state=IDLE, count=0, overflow=0, rd_valid=0, rd_entry=0, pointers=0 and remaining=0; storage contents are not reset.

Structure
REQ-033 Package trace_pkg SHALL hold ENTRY_W, the field bit offsets and the state encodings.
REQ-034 Storage SHALL be sub-module trace_ram: DEPTH x ENTRY_W, one synchronous write port, one asynchronous read port.
REQ-035 The FSM, pointers, counters and trigger compare SHALL reside in trace_buffer.

Verification (DEPTH=16; samples pc=0x00,0x04,... one per cycle)
REQ-036 trig_pc=0x20, post_count=3 -> DONE after pc 0x2C; count=12, overflow=0; reads return 0x00..0x2C in order, then rd_valid=0.
REQ-037 trig_pc=0x40, post_count=4 -> 21 writes; count=16, overflow=1; first read pc=0x14, last read pc=0x50.
REQ-038 trig_pc=0x08, post_count=0 -> DONE the cycle after pc 0x08; count=3; reads 0x00, 0x04, 0x08.
REQ-039 trig_en=0, stop asserted with the 5th sample -> count=5, state=DONE; clear and arm in the same cycle -> state=IDLE, count=0.
REQ-040 reset driven to 0 mid-POST between clock edges -> state=IDLE, count=0, rd_valid=0 immediately; re-arm after release captures normally.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared definitions for the instruction trace buffer: sample layout and FSM encodings.
package trace_pkg;

   localparam int ENTRY_W = 167;

   // Field bit offsets inside a packed sample, MSB first.
   localparam int PC_MSB        = 166;
   localparam int PC_LSB        = 135;
   localparam int INSTR_MSB     = 134;
   localparam int INSTR_LSB     = 103;
   localparam int REG_WE_BIT    = 102;
   localparam int REG_ADDR_MSB  = 101;
   localparam int REG_ADDR_LSB  = 97;
   localparam int REG_WDATA_MSB = 96;
   localparam int REG_WDATA_LSB = 65;
   localparam int MEM_WE_BIT    = 64;
   localparam int MEM_ADDR_MSB  = 63;
   localparam int MEM_ADDR_LSB  = 32;
   localparam int MEM_WDATA_MSB = 31;
   localparam int MEM_WDATA_LSB = 0;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ARMED = 2'b01,
      ST_POST  = 2'b10,
      ST_DONE  = 2'b11
   } state_t;

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port, one asynchronous read port, contents never reset.
module trace_ram #(
   parameter int DEPTH = 16,
   parameter int W     = 167,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] wr_addr,
   input  logic [W-1:0]  wr_data,
   input  logic [AW-1:0] rd_addr,
   output logic [W-1:0]  rd_data
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[wr_addr] <= wr_data;
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/trace_buffer.sv
// Circular instruction trace buffer with PC-match trigger, post-trigger window and drain port.
module trace_buffer
   import trace_pkg::*;
#(
   parameter int DEPTH  = 16,
   parameter int POST_W = 8
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        cap_valid,
   input  logic [ENTRY_W-1:0]          cap_entry,
   input  logic                        trig_en,
   input  logic [31:0]                 trig_pc,
   input  logic [POST_W-1:0]           post_count,
   input  logic                        arm,
   input  logic                        stop,
   input  logic                        clear,
   input  logic                        rd_ready,
   output logic                        rd_valid,
   output logic [ENTRY_W-1:0]          rd_entry,
   output logic [$clog2(DEPTH):0]      count,
   output logic [1:0]                  state,
   output logic                        overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   state_t             st;
   logic [AW-1:0]      wr_ptr;
   logic [AW-1:0]      rd_ptr;
   logic [POST_W-1:0]  remaining;
   logic [ENTRY_W-1:0] ram_rdata;
   logic               capturing;
   logic               wr_en;
   logic               full;
   logic               trig_hit;
   logic               restart;
   logic               rd_fire;

   // clear outranks everything, so a sample arriving with clear is dropped.
   assign capturing = (st == ST_ARMED) || (st == ST_POST);
   assign wr_en     = capturing && cap_valid && !clear;
   assign full      = (count == FULL);
   assign trig_hit  = (st == ST_ARMED) && cap_valid && trig_en &&
                      (cap_entry[PC_MSB:PC_LSB] == trig_pc);
   assign restart   = arm && ((st == ST_IDLE) || (st == ST_DONE));
   assign rd_valid  = (st == ST_DONE) && (count != '0);
   assign rd_fire   = rd_valid && rd_ready;
   assign rd_entry  = rd_valid ? ram_rdata : '0;
   assign state     = st;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st        <= ST_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         remaining <= '0;
         overflow  <= 1'b0;
      end else if (clear || restart) begin
         st        <= clear ? ST_IDLE : ST_ARMED;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         remaining <= '0;
         overflow  <= 1'b0;
      end else begin
         case (st)
            ST_ARMED, ST_POST: begin
               // When full the oldest entry is dropped by dragging rd_ptr along.
               if (wr_en) begin
                  wr_ptr <= wr_ptr + AW'(1);
                  if (full) begin
                     rd_ptr   <= rd_ptr + AW'(1);
                     overflow <= 1'b1;
                  end else begin
                     count <= count + CW'(1);
                  end
               end
               if (stop) begin
                  st <= ST_DONE;
               end else if (trig_hit) begin
                  remaining <= post_count;
                  st        <= (post_count == '0) ? ST_DONE : ST_POST;
               end else if ((st == ST_POST) && wr_en) begin
                  remaining <= remaining - POST_W'(1);
                  if (remaining == POST_W'(1)) st <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (rd_fire) begin
                  rd_ptr <= rd_ptr + AW'(1);
                  count  <= count - CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   trace_ram #(
      .DEPTH (DEPTH),
      .W     (ENTRY_W)
   ) u_ram (
      .clk     (clk),
      .we      (wr_en),
      .wr_addr (wr_ptr),
      .wr_data (cap_entry),
      .rd_addr (rd_ptr),
      .rd_data (ram_rdata)
   );

endmodule

// File: tb/tb_trace_buffer.sv
// Directed bench for trace_buffer: reference queue of stored samples, drained and compared in order.
module tb_trace_buffer;
   import trace_pkg::*;

   localparam int DEPTH  = 16;
   localparam int POST_W = 8;
   localparam int CW     = $clog2(DEPTH) + 1;

   logic               clk = 1'b0;
   logic               reset = 1'b0;
   logic               cap_valid = 1'b0;
   logic [ENTRY_W-1:0] cap_entry = '0;
   logic               trig_en = 1'b0;
   logic [31:0]        trig_pc = '0;
   logic [POST_W-1:0]  post_count = '0;
   logic               arm = 1'b0;
   logic               stop = 1'b0;
   logic               clear = 1'b0;
   logic               rd_ready = 1'b0;
   logic               rd_valid;
   logic [ENTRY_W-1:0] rd_entry;
   logic [CW-1:0]      count;
   logic [1:0]         state;
   logic               overflow;

   logic [ENTRY_W-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   trace_buffer #(.DEPTH(DEPTH), .POST_W(POST_W)) dut (
      .clk        (clk),
      .reset      (reset),
      .cap_valid  (cap_valid),
      .cap_entry  (cap_entry),
      .trig_en    (trig_en),
      .trig_pc    (trig_pc),
      .post_count (post_count),
      .arm        (arm),
      .stop       (stop),
      .clear      (clear),
      .rd_ready   (rd_ready),
      .rd_valid   (rd_valid),
      .rd_entry   (rd_entry),
      .count      (count),
      .state      (state),
      .overflow   (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [ENTRY_W-1:0] obs,
                        input logic [ENTRY_W-1:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [ENTRY_W-1:0] make_entry(input logic [31:0] pc);
      logic [31:0] instr, rwd, maddr, mwd;
      logic [4:0]  ra;
      logic        rwe, mwe;
      instr = $urandom();
      rwd   = $urandom();
      maddr = $urandom();
      mwd   = $urandom();
      ra    = 5'($urandom_range(0, 31));
      rwe   = 1'($urandom_range(0, 1));
      mwe   = 1'($urandom_range(0, 1));
      return {pc, instr, rwe, ra, rwd, mwe, maddr, mwd};
   endfunction

   // Drive one sample; when it should be stored, the model keeps the newest DEPTH entries.
   task automatic send(input logic [31:0] pc, input bit stored, input bit with_stop);
      logic [ENTRY_W-1:0] e;
      e = make_entry(pc);
      cap_valid = 1'b1;
      cap_entry = e;
      stop      = with_stop;
      if (stored) begin
         exp_q.push_back(e);
         if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
      end
      tick();
      cap_valid = 1'b0;
      stop      = 1'b0;
   endtask

   task automatic feed(input int n, input int first_idx);
      for (int i = 0; i < n; i++) send(32'((first_idx + i) * 4), 1'b1, 1'b0);
   endtask

   task automatic pulse_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic drain();
      logic [ENTRY_W-1:0] e;
      rd_ready = 1'b1;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         check("rd_valid_drain", rd_valid, 1);
         check("rd_entry_drain", rd_entry, e);
         tick();
      end
      rd_ready = 1'b0;
      check("rd_valid_empty", rd_valid, 0);
      check("rd_entry_empty", rd_entry, 0);
      check("state_after_drain", state, ST_DONE);
      check("count_after_drain", count, 0);
   endtask

   initial begin
      // Reset values while reset is held low.
      #2;
      check("rst_state", state, ST_IDLE);
      check("rst_count", count, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_entry", rd_entry, 0);
      check("rst_overflow", overflow, 0);
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Samples in IDLE are ignored, stop in IDLE is ignored.
      send(32'h100, 1'b0, 1'b1);
      check("idle_ignore_count", count, 0);
      check("idle_ignore_state", state, ST_IDLE);

      // Trigger at 0x20 with 3 post samples.
      trig_en = 1'b1; trig_pc = 32'h20; post_count = 8'd3;
      pulse_arm();
      check("armed_state", state, ST_ARMED);
      feed(11, 0);
      check("post_state", state, ST_POST);
      check("post_rd_valid", rd_valid, 0);
      feed(1, 11);
      check("t1_state", state, ST_DONE);
      check("t1_count", count, 12);
      check("t1_overflow", overflow, 0);
      send(32'h30, 1'b0, 1'b0);
      send(32'h34, 1'b0, 1'b0);
      check("t1_done_ignores", count, 12);
      check("t1_first_pc", rd_entry[PC_MSB:PC_LSB], 32'h0);
      drain();

      // Wrap-around: trigger at 0x40, 4 post samples, 21 writes.
      trig_pc = 32'h40; post_count = 8'd4;
      pulse_arm();
      check("t2_armed", state, ST_ARMED);
      feed(21, 0);
      check("t2_state", state, ST_DONE);
      check("t2_count", count, 16);
      check("t2_overflow", overflow, 1);
      check("t2_first_pc", rd_entry[PC_MSB:PC_LSB], 32'h14);
      check("t2_last_model_pc", exp_q[exp_q.size()-1][PC_MSB:PC_LSB], 32'h50);
      drain();

      // Zero post count: done right after the trigger sample.
      trig_pc = 32'h08; post_count = 8'd0;
      pulse_arm();
      check("t3_overflow_cleared", overflow, 0);
      feed(3, 0);
      check("t3_state", state, ST_DONE);
      check("t3_count", count, 3);
      drain();

      // No trigger: stop arrives with the 5th sample, which is still kept.
      trig_en = 1'b0;
      pulse_arm();
      feed(4, 0);
      check("t4_armed_no_trig", state, ST_ARMED);
      send(32'h10, 1'b1, 1'b1);
      check("t4_state", state, ST_DONE);
      check("t4_count", count, 5);
      clear = 1'b1; arm = 1'b1;
      tick();
      clear = 1'b0; arm = 1'b0;
      check("t4_clear_state", state, ST_IDLE);
      check("t4_clear_count", count, 0);
      check("t4_clear_rd_valid", rd_valid, 0);
      exp_q.delete();

      // Asynchronous reset in the middle of POST.
      trig_en = 1'b1; trig_pc = 32'h20; post_count = 8'd3;
      pulse_arm();
      feed(10, 0);
      check("t5_in_post", state, ST_POST);
      #2;
      reset = 1'b0;
      #1;
      check("t5_rst_state", state, ST_IDLE);
      check("t5_rst_count", count, 0);
      check("t5_rst_rd_valid", rd_valid, 0);
      check("t5_rst_rd_entry", rd_entry, 0);
      exp_q.delete();
      @(negedge clk);
      reset = 1'b1;
      tick();

      // Re-arm after reset: trigger at 0x08 with one post sample.
      trig_pc = 32'h08; post_count = 8'd1;
      pulse_arm();
      feed(4, 0);
      check("t6_state", state, ST_DONE);
      check("t6_count", count, 4);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
